vin_slice_serializer: RTL and testbench
=======================================

VIN_SLICE_SERIALIZER -- requirements
Module: vin_slice_serializer

Interface
REQ-001 SHALL provide ports: clk  in  1  system clock, nominally 14 MHz, same as VIN/GEN.
REQ-002 SHALL provide: _rst  in  1  asynchronous active-low reset.
REQ-003 SHALL provide: pix_en  in  1  pixel-clock enable, one clk-wide pulse per pixel.
REQ-004 SHALL provide: char_start  in  1  cell-start strobe; counts only when coincident with pix_en.
REQ-005 SHALL provide: _sg  in  1  slice gate; GEN drives busA while low.
REQ-006 SHALL provide: busA  in  8  slice byte from GEN, bit 7 = leftmost pixel.
REQ-007 SHALL provide: attr  in  8  [2:0] fg RGB, [5:3] bg RGB, [6] invert, [7] flash.
REQ-008 SHALL provide: dw  in  1  double-width request, sampled with the slice.
REQ-009 SHALL provide: flash_phase  in  1  blink phase; blank  in  1  forces black.
REQ-010 SHALL provide: status_clr  in  1  clears sticky flags.
REQ-011 SHALL provide: rgb  out  3  registered pixel colour.
REQ-012 SHALL provide: underrun  out  1  sticky; overrun  out  1  sticky.

Function
REQ-013 SHALL capture busA, attr and dw into a holding register on the clk where a rising edge of _sg is detected from a two-stage synchroniser (sampling the second stage), and set hold_valid.
REQ-014 SHALL, when a capture occurs while hold_valid=1 and no transfer occurs on the same clk, overwrite the holding register and set overrun.
REQ-015 SHALL, on pix_en & char_start, transfer the holding register to the shift register, load bit counter 0, and clear hold_valid.
REQ-016 SHALL, on pix_en & char_start with hold_valid=0, load slice 0x00 with the previous attributes and set underrun.
REQ-017 SHALL, on simultaneous capture and transfer, transfer the old holding contents and leave the new capture held with hold_valid=1; overrun is not set.
REQ-018 SHALL shift MSB-first, one bit per pix_en, for 8 pixels; bit counter 3 bits, wraps 7->0 into idle.
REQ-019 SHALL, in idle (after 8 pixels, before the next char_start), present pixel bit 0, i.e. bg colour.
REQ-020 SHALL form pixel = shift_msb XOR invert, then force pixel=0 when flash=1 and flash_phase=1.
REQ-021 SHALL drive rgb = blank ? 3'b000 : (pixel ? fg : bg), registered on the same clk as pix_en (one-clk latency from pix_en); rgb holds between pix_en pulses.
REQ-022 SHALL form the state machine IDLE -> SHIFT (on char_start) -> IDLE (after last pixel); char_start during SHIFT restarts SHIFT with the new load (truncating the old cell).
REQ-023 SHALL clear underrun and overrun on status_clr; set takes priority over clear on the same clk.

Reset
REQ-024 SHALL, while _rst=0: rgb=000, underrun=0, overrun=0, hold_valid=0, shift register=0x00, attributes=0x00, state IDLE, and synchroniser stages=1 (so no false edge at release).
REQ-025 SHALL abort any cell in progress on reset; the first pixel after release is bg of attribute 0x00 (black).

Configuration
REQ-026 SHALL, with VIN_DOUBLE_WIDTH_EN defined, shift one bit every second pix_en when captured dw=1 (16-pixel cell, 4-bit counter); dw=0 behaves as REQ-018.
REQ-027 SHALL, without VIN_DOUBLE_WIDTH_EN, ignore dw and build only the 3-bit counter path.

Verification
REQ-028 SHALL cover: _sg pulse with busA=0xA5, attr=0x38 (fg 000, bg 111), then char_start -> rgb over 8 pix_en = 000,111,000,111,111,000,111,000.
REQ-029 SHALL cover: char_start with no prior capture -> bg colour for 8 pixels and underrun=1 until status_clr.
REQ-030 SHALL cover: two _sg captures (0xFF then 0x0F) before char_start -> overrun=1 and cell shows 0x0F pattern.
REQ-031 SHALL cover: attr=0xC7, busA=0xF0, flash_phase=1 -> all 8 pixels bg 000; flash_phase=0 -> inverted pattern 000x4 then 111x4.
REQ-032 SHALL cover: _rst asserted at pixel 3 of a cell -> rgb=000 immediately (asynchronous), flags 0, and no capture at reset release.
REQ-033 SHALL cover, with VIN_DOUBLE_WIDTH_EN: dw=1, busA=0x80, fg=111 -> 2 pixels 111, then 14 pixels bg.

Source files
------------

// File: rtl/vin_slice_serializer_if.sv
// Slice/attribute bus between GEN/VIN timing and the slice serializer.
// master = the pixel-timing side driving strobes and data, slave = the serializer.
interface vin_slice_serializer_if;
  logic       pix_en;
  logic       char_start;
  logic       _sg;
  logic [7:0] busA;
  logic [7:0] attr;
  logic       dw;
  logic       flash_phase;
  logic       blank;
  logic       status_clr;
  logic [2:0] rgb;
  logic       underrun;
  logic       overrun;

  modport master (
    output pix_en, char_start, _sg, busA, attr, dw, flash_phase, blank, status_clr,
    input  rgb, underrun, overrun
  );

  modport slave (
    input  pix_en, char_start, _sg, busA, attr, dw, flash_phase, blank, status_clr,
    output rgb, underrun, overrun
  );
endinterface

// File: rtl/vin_slice_serializer.sv
// Captures a GEN slice on the rising edge of _sg and serializes it MSB-first into RGB pixels.
// Optional VIN_DOUBLE_WIDTH_EN: captured dw=1 stretches each bit over two pix_en (16-pixel cell).
module vin_slice_serializer (
  input logic                   clk,
  input logic                   _rst,
  vin_slice_serializer_if.slave io
);

`ifdef VIN_DOUBLE_WIDTH_EN
  localparam int CW = 4;
`else
  localparam int CW = 3;
`endif
  localparam logic [CW-1:0] LAST_N = CW'(7);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // _sg synchroniser plus edge-detect stage; all reset high so release never looks like an edge
  logic sg_s1_q, sg_s2_q, sg_s3_q;
  logic cap, xfer;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      sg_s1_q <= 1'b1;
      sg_s2_q <= 1'b1;
      sg_s3_q <= 1'b1;
    end else begin
      sg_s1_q <= io._sg;
      sg_s2_q <= sg_s1_q;
      sg_s3_q <= sg_s2_q;
    end
  end

  assign cap  = sg_s2_q & ~sg_s3_q;
  assign xfer = io.pix_en & io.char_start;

  // Holding register
  logic [7:0] hold_byte_q, hold_attr_q;
  logic       hold_valid_q, hold_valid_d;
`ifdef VIN_DOUBLE_WIDTH_EN
  logic       hold_dw_q;
`else
  logic       unused_dw;
  assign unused_dw = io.dw;
`endif

  assign hold_valid_d = cap | (hold_valid_q & ~xfer);

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      hold_byte_q  <= 8'h00;
      hold_attr_q  <= 8'h00;
      hold_valid_q <= 1'b0;
`ifdef VIN_DOUBLE_WIDTH_EN
      hold_dw_q    <= 1'b0;
`endif
    end else begin
      hold_valid_q <= hold_valid_d;
      if (cap) begin
        hold_byte_q <= io.busA;
        hold_attr_q <= io.attr;
`ifdef VIN_DOUBLE_WIDTH_EN
        hold_dw_q   <= io.dw;
`endif
      end
    end
  end

  // Shifter / cell state
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    attr_q, attr_d;
  logic          step, last;
`ifdef VIN_DOUBLE_WIDTH_EN
  logic          dw_q, dw_d;
  localparam logic [CW-1:0] LAST_W = CW'(15);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    attr_d  = attr_q;
`ifdef VIN_DOUBLE_WIDTH_EN
    dw_d    = dw_q;
    step    = ~dw_q | cnt_q[0];
    last    = dw_q ? (cnt_q == LAST_W) : (cnt_q == LAST_N);
`else
    step    = 1'b1;
    last    = (cnt_q == LAST_N);
`endif
    if (xfer) begin
      // A new cell always wins, truncating whatever was still shifting
      state_d = ST_SHIFT;
      cnt_d   = '0;
      if (hold_valid_q) begin
        shift_d = hold_byte_q;
        attr_d  = hold_attr_q;
`ifdef VIN_DOUBLE_WIDTH_EN
        dw_d    = hold_dw_q;
`endif
      end else begin
        shift_d = 8'h00;
`ifdef VIN_DOUBLE_WIDTH_EN
        dw_d    = 1'b0;
`endif
      end
    end else if (io.pix_en && state_q == ST_SHIFT) begin
      cnt_d = cnt_q + CW'(1);
      if (step) shift_d = {shift_q[6:0], 1'b0};
      if (last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Pixel shown on a pix_en comes from the state before that pix_en's load/shift,
  // so a cell's first pixel appears on the pix_en after its char_start.
  logic       pix;
  logic [2:0] rgb_d, rgb_q;

  always_comb begin
    pix = (shift_q[7] ^ attr_q[6]) & ~(attr_q[7] & io.flash_phase);
    if (state_q == ST_IDLE) pix = 1'b0;
    rgb_d = io.blank ? 3'b000 : (pix ? attr_q[2:0] : attr_q[5:3]);
  end

  logic underrun_q, underrun_d, overrun_q, overrun_d;

  // Set beats clear on the same clk
  assign underrun_d = (xfer & ~hold_valid_q) | (underrun_q & ~io.status_clr);
  assign overrun_d  = (cap & hold_valid_q & ~xfer) | (overrun_q & ~io.status_clr);

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= 8'h00;
      attr_q     <= 8'h00;
      rgb_q      <= 3'b000;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef VIN_DOUBLE_WIDTH_EN
      dw_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      attr_q     <= attr_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
`ifdef VIN_DOUBLE_WIDTH_EN
      dw_q       <= dw_d;
`endif
      if (io.pix_en) rgb_q <= rgb_d;
    end
  end

  assign io.rgb      = rgb_q;
  assign io.underrun = underrun_q;
  assign io.overrun  = overrun_q;

endmodule

// File: tb/tb_vin_slice_serializer.sv
// Self-checking bench for vin_slice_serializer: directed scenarios plus random traffic
// against a queue-based pixel model.
module tb_vin_slice_serializer;
  logic clk = 1'b0;
  logic _rst;
  always #5 clk = ~clk;

  vin_slice_serializer_if io ();
  vin_slice_serializer dut (.clk(clk), ._rst(_rst), .io(io.slave));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a cell is a queue of pixel bits, colours formed when each pops
  bit         h1, h2, h3;
  logic [7:0] mh_b, mh_a, m_attr;
  bit         mh_dw, mh_v, m_un, m_ov;
  logic [2:0] m_rgb;
  bit         m_q[$];

  task automatic m_reset();
    h1 = 1; h2 = 1; h3 = 1;
    mh_b = 0; mh_a = 0; mh_dw = 0; mh_v = 0;
    m_attr = 0; m_un = 0; m_ov = 0; m_rgb = 0;
    m_q.delete();
  endtask

  task automatic step();
    bit cap, xfer, p, b, set_un, set_ov, new_v;
    cap  = h2 && !h3;
    xfer = io.pix_en && io.char_start;
    if (io.pix_en) begin
      p = 0;
      if (m_q.size() > 0) begin
        b = m_q.pop_front();
        p = b ^ m_attr[6];
        if (m_attr[7] && io.flash_phase) p = 0;
      end
      m_rgb = io.blank ? 3'b000 : (p ? m_attr[2:0] : m_attr[5:3]);
    end
    set_un = xfer && !mh_v;
    set_ov = cap && mh_v && !xfer;
    if (xfer) begin
      m_q.delete();
      if (mh_v) begin
        m_attr = mh_a;
        for (int i = 7; i >= 0; i--) begin
          m_q.push_back(mh_b[i]);
`ifdef VIN_DOUBLE_WIDTH_EN
          if (mh_dw) m_q.push_back(mh_b[i]);
`endif
        end
      end else begin
        for (int i = 0; i < 8; i++) m_q.push_back(1'b0);
      end
    end
    new_v = cap ? 1'b1 : (xfer ? 1'b0 : mh_v);
    if (cap) begin
      mh_b = io.busA; mh_a = io.attr; mh_dw = io.dw;
    end
    mh_v = new_v;
    m_un = set_un || (m_un && !io.status_clr);
    m_ov = set_ov || (m_ov && !io.status_clr);
    h3 = h2; h2 = h1; h1 = io._sg;
    @(posedge clk); #1;
  endtask

  task automatic cyc(input bit pe, input bit cs);
    io.pix_en = pe; io.char_start = cs;
    step();
    io.pix_en = 0; io.char_start = 0;
  endtask

  task automatic load_slice(input logic [7:0] b, input logic [7:0] a, input bit d);
    io._sg = 0; io.busA = b; io.attr = a; io.dw = d;
    cyc(0, 0); cyc(0, 0);
    io._sg = 1;
    repeat (4) cyc(0, 0);
  endtask

  task automatic clear_flags();
    io.status_clr = 1; cyc(0, 0); io.status_clr = 0;
  endtask

  task automatic test_reset();
    _rst = 0;
    io.pix_en = 0; io.char_start = 0; io._sg = 1; io.busA = 0; io.attr = 0;
    io.dw = 0; io.flash_phase = 0; io.blank = 0; io.status_clr = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk += 3;
    if (io.rgb !== 3'b000)   begin n_fail++; $display("FAIL reset_rgb: got %b want 000", io.rgb); end
    if (io.underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", io.underrun); end
    if (io.overrun !== 1'b0)  begin n_fail++; $display("FAIL reset_overrun: got %b want 0", io.overrun); end
    #4 _rst = 1;
  endtask

  task automatic test_basic();
    logic [2:0] exp [8];
    exp = '{3'b000, 3'b111, 3'b000, 3'b111, 3'b111, 3'b000, 3'b111, 3'b000};
    load_slice(8'hA5, 8'h38, 0);
    cyc(1, 1); cyc(0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      n_chk++;
      if (io.rgb !== exp[i]) begin n_fail++; $display("FAIL basic_px%0d: got %b want %b", i, io.rgb, exp[i]); end
      cyc(0, 0);
      n_chk++;
      if (io.rgb !== exp[i]) begin n_fail++; $display("FAIL basic_hold%0d: got %b want %b", i, io.rgb, exp[i]); end
    end
    cyc(1, 0);
    n_chk++;
    if (io.rgb !== 3'b111) begin n_fail++; $display("FAIL basic_idle_bg: got %b want 111", io.rgb); end
  endtask

  task automatic test_underrun();
    clear_flags();
    cyc(1, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      n_chk++;
      if (io.rgb !== 3'b111) begin n_fail++; $display("FAIL underrun_px%0d: got %b want 111", i, io.rgb); end
    end
    n_chk++;
    if (io.underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b want 1", io.underrun); end
    clear_flags();
    n_chk++;
    if (io.underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clr: got %b want 0", io.underrun); end
    io.status_clr = 1; cyc(1, 1); io.status_clr = 0;
    n_chk++;
    if (io.underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set_prio: got %b want 1", io.underrun); end
    clear_flags();
  endtask

  task automatic test_overrun();
    logic [7:0] b;
    logic [2:0] e;
    b = 8'h0F;
    load_slice(8'hFF, 8'h38, 0);
    n_chk++;
    if (io.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_first: got %b want 0", io.overrun); end
    load_slice(b, 8'h38, 0);
    n_chk++;
    if (io.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", io.overrun); end
    cyc(1, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      e = b[7-i] ? 3'b000 : 3'b111;
      n_chk++;
      if (io.rgb !== e) begin n_fail++; $display("FAIL overrun_px%0d: got %b want %b", i, io.rgb, e); end
    end
    clear_flags();
  endtask

  task automatic test_flash();
    logic [2:0] e;
    io.flash_phase = 1;
    load_slice(8'hF0, 8'hC7, 0);
    cyc(1, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      n_chk++;
      if (io.rgb !== 3'b000) begin n_fail++; $display("FAIL flash_on_px%0d: got %b want 000", i, io.rgb); end
    end
    io.flash_phase = 0;
    load_slice(8'hF0, 8'hC7, 0);
    cyc(1, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      e = (i < 4) ? 3'b000 : 3'b111;
      n_chk++;
      if (io.rgb !== e) begin n_fail++; $display("FAIL flash_inv_px%0d: got %b want %b", i, io.rgb, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2;
    logic [2:0] e;
    b1 = 8'h3C; b2 = 8'hC3;
    clear_flags();
    load_slice(b1, 8'h38, 0);
    io._sg = 0; io.busA = b2;
    cyc(0, 0); cyc(0, 0);
    io._sg = 1;
    cyc(0, 0); cyc(0, 0);
    cyc(1, 1);                      // capture of b2 lands on this transfer
    n_chk++;
    if (io.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun: got %b want 0", io.overrun); end
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      e = b1[7-i] ? 3'b000 : 3'b111;
      n_chk++;
      if (io.rgb !== e) begin n_fail++; $display("FAIL b2b_old_px%0d: got %b want %b", i, io.rgb, e); end
    end
    cyc(1, 1);
    n_chk++;
    if (io.underrun !== 1'b0) begin n_fail++; $display("FAIL b2b_held: got %b want 0", io.underrun); end
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      e = b2[7-i] ? 3'b000 : 3'b111;
      n_chk++;
      if (io.rgb !== e) begin n_fail++; $display("FAIL b2b_new_px%0d: got %b want %b", i, io.rgb, e); end
    end
  endtask

`ifdef VIN_DOUBLE_WIDTH_EN
  task automatic test_double_width();
    logic [2:0] e;
    load_slice(8'h80, 8'h07, 1);
    cyc(1, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0);
      e = (i < 2) ? 3'b111 : 3'b000;
      n_chk++;
      if (io.rgb !== e) begin n_fail++; $display("FAIL dw_px%0d: got %b want %b", i, io.rgb, e); end
    end
    io.dw = 0;
  endtask
`endif

  task automatic test_reset_midcell();
    clear_flags();
    load_slice(8'h00, 8'h38, 0);
    cyc(1, 1);
    load_slice(8'hFF, 8'h38, 0);
    io.status_clr = 1; io._sg = 0; cyc(0, 0); io.status_clr = 0;
    io._sg = 1; cyc(0, 0);
    io.status_clr = 0;
    repeat (3) cyc(1, 0);
    load_slice(8'hAA, 8'h38, 0);    // overrun so reset has a flag to clear
    n_chk++;
    if (io.rgb !== 3'b111) begin n_fail++; $display("FAIL rstmid_pre_rgb: got %b want 111", io.rgb); end
    #2 _rst = 0;
    #1;
    m_reset();
    n_chk += 3;
    if (io.rgb !== 3'b000)    begin n_fail++; $display("FAIL rstmid_rgb: got %b want 000", io.rgb); end
    if (io.underrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_underrun: got %b want 0", io.underrun); end
    if (io.overrun !== 1'b0)  begin n_fail++; $display("FAIL rstmid_overrun: got %b want 0", io.overrun); end
    repeat (3) @(posedge clk);
    #4 _rst = 1;
    cyc(1, 0);
    n_chk++;
    if (io.rgb !== 3'b000) begin n_fail++; $display("FAIL rstmid_first_px: got %b want 000", io.rgb); end
    cyc(1, 1);
    n_chk++;
    if (io.underrun !== 1'b1) begin n_fail++; $display("FAIL rstmid_no_capture: got %b want 1", io.underrun); end
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      n_chk++;
      if (io.rgb !== 3'b000) begin n_fail++; $display("FAIL rstmid_px%0d: got %b want 000", i, io.rgb); end
    end
    clear_flags();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) io._sg = ~io._sg;
      io.busA        = 8'($urandom);
      io.attr        = 8'($urandom);
      io.dw          = 1'($urandom);
      io.pix_en      = ($urandom_range(1) == 0);
      io.char_start  = ($urandom_range(7) == 0);
      io.status_clr  = ($urandom_range(19) == 0);
      io.blank       = ($urandom_range(9) == 0);
      if ($urandom_range(29) == 0) io.flash_phase = ~io.flash_phase;
      step();
      n_chk += 3;
      if (io.rgb !== m_rgb)     begin n_fail++; $display("FAIL rand_rgb@%0d: got %b want %b", c, io.rgb, m_rgb); end
      if (io.underrun !== m_un) begin n_fail++; $display("FAIL rand_underrun@%0d: got %b want %b", c, io.underrun, m_un); end
      if (io.overrun !== m_ov)  begin n_fail++; $display("FAIL rand_overrun@%0d: got %b want %b", c, io.overrun, m_ov); end
    end
    io.pix_en = 0; io.char_start = 0; io.status_clr = 0; io.blank = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_flash();
    test_back_to_back();
`ifdef VIN_DOUBLE_WIDTH_EN
    test_double_width();
`endif
    test_reset_midcell();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
